io_input_reader: RTL and testbench

- Memory-mapped GPIO input port, read by the RISC-V core on the same bus signals as the GPIO output controller (riscv_addr/wdata/wmask/rstrb).
- Brings 32 asynchronous external inputs into the clk domain with a 2-flop synchronizer and per-bit debounce.
- Latches rising edges into a sticky write-1-to-clear status register.
- Drives a maskable interrupt and returns registered read data to the core.

---
 rtl/io_input_reader_if.sv | 20 ++
 rtl/io_input_reader.sv | 132 +++++++++++++
 tb/tb_io_input_reader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/io_input_reader_if.sv
// Core-side bus between the RISC-V core and the GPIO input reader.
// The master drives address, write data, byte mask and read strobe. The slave returns read data and rvalid.
interface io_input_reader_if;
    logic [31:0] riscv_addr;
    logic [31:0] riscv_wdata;
    logic [3:0]  riscv_wmask;
    logic        riscv_rstrb;
    logic [31:0] riscv_rdata;
    logic        riscv_rvalid;

    modport master (
        output riscv_addr, riscv_wdata, riscv_wmask, riscv_rstrb,
        input  riscv_rdata, riscv_rvalid
    );

    modport slave (
        input  riscv_addr, riscv_wdata, riscv_wmask, riscv_rstrb,
        output riscv_rdata, riscv_rvalid
    );
endinterface

// File: rtl/io_input_reader.sv
// Memory-mapped GPIO input port: synchronizer, per-bit debounce and sticky rising-edge status.
// It also provides a maskable interrupt and registered read data for the core.
module io_input_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] ADDR_DATA       = 32'h00000FF8,
    parameter logic [31:0] ADDR_STATUS     = 32'h00000FF4,
    parameter logic [31:0] ADDR_MASK       = 32'h00000FF0
) (
    input  logic               clk,
    input  logic               reset_n,
    io_input_reader_if.slave   bus,
    input  logic [31:0]        gpio_in,
    output logic               gpio_irq
);

    logic [31:0] sync1_q, sync_q;
    logic [31:0] deb_q, deb_prev_q;
    logic [31:0] status_q, status_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] lane;
    logic [31:0] clr;
    logic        wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync_q  <= sync1_q;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) deb_q <= '0;
            else          deb_q <= sync_q;
        end
    end else begin : g_debounce
        localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] cnt_q [32];
        logic [CW-1:0] cnt_d [32];
        logic [31:0]   deb_d;

        // A bit whose synchronized value matches the debounced value restarts its count.
        // This makes glitches shorter than the window invisible.
        always_comb begin
            deb_d = deb_q;
            for (int unsigned i = 0; i < 32; i++) begin
                cnt_d[i] = cnt_q[i];
                if (sync_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                deb_q <= '0;
                for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= '0;
            end else begin
                deb_q <= deb_d;
                for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        lane = '0;
        for (int unsigned k = 0; k < 4; k++) lane[8*k +: 8] = {8{bus.riscv_wmask[k]}};
    end

    assign wr = |bus.riscv_wmask;

    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr && bus.riscv_addr == ADDR_MASK)
            mask_d = (mask_q & ~lane) | (bus.riscv_wdata & lane);
        if (wr && bus.riscv_addr == ADDR_STATUS)
            clr = bus.riscv_wdata & lane;
        // A new edge is ORed in after the clear, so an edge wins over a same-cycle clear.
        status_d = (status_q & ~clr) | (deb_q & ~deb_prev_q);
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (bus.riscv_rstrb) begin
            if (bus.riscv_addr == ADDR_DATA) begin
                rdata_d  = deb_q;
                rvalid_d = 1'b1;
            end else if (bus.riscv_addr == ADDR_STATUS) begin
                rdata_d  = status_q;
                rvalid_d = 1'b1;
            end else if (bus.riscv_addr == ADDR_MASK) begin
                rdata_d  = mask_q;
                rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev_q <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            deb_prev_q <= deb_q;
            status_q   <= status_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign bus.riscv_rdata  = rdata_q;
    assign bus.riscv_rvalid = rvalid_q;
    assign gpio_irq         = |(status_q & mask_q);

endmodule

// File: tb/tb_io_input_reader.sv
// Self-checking bench for io_input_reader, built with a 4-cycle debounce window.
// Every read is checked against a queue of expected read data.
module tb_io_input_reader;

    localparam logic [31:0] A_DATA   = 32'h00000FF8;
    localparam logic [31:0] A_STATUS = 32'h00000FF4;
    localparam logic [31:0] A_MASK   = 32'h00000FF0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] gpio_in;
    logic        gpio_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rstrb;
        logic        hit;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    io_input_reader_if bus ();

    io_input_reader #(
        .DEBOUNCE_CYCLES (4),
        .ADDR_DATA       (A_DATA),
        .ADDR_STATUS     (A_STATUS),
        .ADDR_MASK       (A_MASK)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_irq (gpio_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.riscv_addr  = '0;
        bus.riscv_wdata = '0;
        bus.riscv_wmask = '0;
        bus.riscv_rstrb = 1'b0;
    endtask

    // The bus drive lands on a falling edge and is sampled on the next rising edge.
    task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                      input logic rs, input logic hit, input logic [31:0] exp);
        @(negedge clk);
        bus.riscv_addr  = a;
        bus.riscv_wdata = wd;
        bus.riscv_wmask = wm;
        bus.riscv_rstrb = rs;
        if (rs && hit) exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op('0, '0, 4'h0, 1'b0, 1'b0, '0);
    endtask

    // The read monitor pops one expected value per rvalid pulse.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.riscv_rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid actual=1 required=0 rdata=%h", bus.riscv_rdata);
                end else begin
                    chk("rd_scoreboard", bus.riscv_rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{A_MASK,        32'hA5A51234, 4'hF,    1'b0, 1'b0, 32'h0};
        vecs[1]  = '{A_MASK,        32'h0,        4'h0,    1'b1, 1'b1, 32'hA5A51234};
        vecs[2]  = '{A_MASK,        32'hFFFFFFFF, 4'b0100, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{A_MASK,        32'h0,        4'h0,    1'b1, 1'b1, 32'hA5FF1234};
        vecs[4]  = '{A_MASK,        32'h0,        4'b1001, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{A_MASK,        32'hFFFFFFFF, 4'hF,    1'b1, 1'b1, 32'h00FF1200};
        vecs[6]  = '{A_MASK,        32'h0,        4'h0,    1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[7]  = '{A_DATA,        32'h12345678, 4'hF,    1'b1, 1'b1, 32'h0};
        vecs[8]  = '{32'h00000200,  32'h0,        4'hF,    1'b0, 1'b0, 32'h0};
        vecs[9]  = '{A_MASK,        32'h0,        4'h0,    1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[10] = '{A_STATUS,      32'hFFFFFFFF, 4'hF,    1'b1, 1'b1, 32'h0};
        vecs[11] = '{A_MASK,        32'h0,        4'hF,    1'b0, 1'b0, 32'h0};
        vecs[12] = '{A_MASK,        32'h0,        4'h0,    1'b1, 1'b1, 32'h0};

        reset_n = 1'b0;
        gpio_in = '0;
        set_idle();

        // Reset state, and an asynchronous reset with status and mask loaded while a read is in flight.
        repeat (3) @(negedge clk);
        chk("reset_rdata", bus.riscv_rdata, 32'h0);
        chk("reset_rvalid", {31'b0, bus.riscv_rvalid}, 32'h0);
        chk("reset_irq", {31'b0, gpio_irq}, 32'h0);
        reset_n = 1'b1;
        op(A_MASK, 32'hFF, 4'hF, 1'b0, 1'b0, '0);
        gpio_in = 32'hFF;
        idle(8);
        op(A_STATUS, '0, 4'h0, 1'b1, 1'b1, 32'hFF);
        chk("pre_reset_irq", {31'b0, gpio_irq}, 32'h1);
        op(A_MASK, '0, 4'h0, 1'b1, 1'b1, 32'hFF);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        gpio_in = '0;
        set_idle();
        #1;
        chk("midrst_rdata", bus.riscv_rdata, 32'h0);
        chk("midrst_rvalid", {31'b0, bus.riscv_rvalid}, 32'h0);
        chk("midrst_irq", {31'b0, gpio_irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        op(A_STATUS, '0, 4'h0, 1'b1, 1'b1, 32'h0);
        op(A_MASK, '0, 4'h0, 1'b1, 1'b1, 32'h0);
        idle(1);

        // Register access table: byte lanes, read-before-write, and ignored writes.
        for (int i = 0; i < 13; i++)
            op(vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].rstrb, vecs[i].hit, vecs[i].exp);
        idle(2);

        // Debounce latency: gpio_in[0] rises before edge n.
        op(A_MASK, 32'h1, 4'hF, 1'b0, 1'b0, '0);
        idle(1);
        gpio_in[0] = 1'b1;                          // before edge n
        idle(3);
        op(A_DATA, '0, 4'h0, 1'b1, 1'b1, 32'h0);    // strobe at edge n+4
        idle(1);
        op(A_DATA, '0, 4'h0, 1'b1, 1'b1, 32'h1);    // strobe at edge n+6
        chk("irq_before_n6", {31'b0, gpio_irq}, 32'h0);
        idle(1);
        chk("irq_after_n6", {31'b0, gpio_irq}, 32'h1);

        // Glitch rejection: gpio_in[3] is high for three cycles only.
        idle(1);
        gpio_in[3] = 1'b1;
        idle(3);
        gpio_in[3] = 1'b0;
        op(A_STATUS, 32'h1, 4'hF, 1'b0, 1'b0, '0);
        idle(10);
        op(A_DATA, '0, 4'h0, 1'b1, 1'b1, 32'h1);
        op(A_STATUS, '0, 4'h0, 1'b1, 1'b1, 32'h0);
        idle(1);
        chk("glitch_irq", {31'b0, gpio_irq}, 32'h0);

        // Interrupt path: a lane-0 mask write, then an edge on bit 2, then a W1C.
        op(A_MASK, 32'h00000005, 4'b0001, 1'b0, 1'b0, '0);
        gpio_in[2] = 1'b1;
        idle(8);
        chk("irq_bit2_set", {31'b0, gpio_irq}, 32'h1);
        op(A_STATUS, '0, 4'h0, 1'b1, 1'b1, 32'h4);
        op(A_STATUS, 32'h4, 4'hF, 1'b0, 1'b0, '0);
        idle(1);
        chk("irq_after_w1c", {31'b0, gpio_irq}, 32'h0);
        op(A_STATUS, '0, 4'h0, 1'b1, 1'b1, 32'h0);

        // Collision: a W1C of bit 1 on the same edge that captures bit 1 rising.
        idle(1);
        gpio_in[1] = 1'b1;                          // before edge n
        idle(5);
        op(A_STATUS, 32'h2, 4'hF, 1'b0, 1'b0, '0);  // edge n+6
        op(A_STATUS, '0, 4'h0, 1'b1, 1'b1, 32'h2);
        op(A_STATUS, 32'h2, 4'hF, 1'b0, 1'b0, '0);
        op(A_STATUS, '0, 4'h0, 1'b1, 1'b1, 32'h0);

        // Read protocol: back-to-back mask reads, then an unmapped read.
        op(A_MASK, '0, 4'h0, 1'b1, 1'b1, 32'h5);
        op(A_MASK, '0, 4'h0, 1'b1, 1'b1, 32'h5);
        chk("b2b_rvalid_1", {31'b0, bus.riscv_rvalid}, 32'h1);
        op(32'h00000100, '0, 4'h0, 1'b1, 1'b0, '0);
        chk("b2b_rvalid_2", {31'b0, bus.riscv_rvalid}, 32'h1);
        idle(1);
        chk("unmapped_rvalid", {31'b0, bus.riscv_rvalid}, 32'h0);
        chk("unmapped_rdata_hold", bus.riscv_rdata, 32'h5);

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
